// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and loads IF/ID.
// Per-edge priority: reset, redirect, stall (hold), memory conflict (bubble), normal fetch.
module if_stage #(
   parameter int                PC_W     = 16,
   parameter int                INST_W   = 16,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(16'h0800)
) (
   input  logic              clk,
   input  logic              rst,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_data,
   input  logic              stall,
   input  logic              mem_conflict,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic [PC_W-1:0]   if_id_pc,
   output logic [PC_W-1:0]   if_id_pc_plus1,
   output logic [INST_W-1:0] if_id_inst,
   output logic              if_id_valid
);

   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   r_if_id_pc;
   logic [PC_W-1:0]   r_if_id_pc_plus1;
   logic [INST_W-1:0] r_if_id_inst;
   logic              r_if_id_valid;
   logic [PC_W-1:0]   w_pc_plus1;

   // Wraps modulo 2^PC_W; no carry is kept.
   assign w_pc_plus1 = r_pc + PC_W'(1);
   assign imem_addr  = r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc             <= RESET_PC;
         r_if_id_pc       <= '0;
         r_if_id_pc_plus1 <= '0;
         r_if_id_inst     <= NOP_INST;
         r_if_id_valid    <= 1'b0;
      end else if (redirect) begin
         // Squash the wrong-path fetch even if stall or conflict is also raised.
         r_pc             <= redirect_pc;
         r_if_id_pc       <= '0;
         r_if_id_pc_plus1 <= '0;
         r_if_id_inst     <= NOP_INST;
         r_if_id_valid    <= 1'b0;
      end else if (stall) begin
         r_pc             <= r_pc;
         r_if_id_pc       <= r_if_id_pc;
         r_if_id_pc_plus1 <= r_if_id_pc_plus1;
         r_if_id_inst     <= r_if_id_inst;
         r_if_id_valid    <= r_if_id_valid;
      end else if (mem_conflict) begin
         // imem_data is not ours this cycle: insert a bubble and refetch the same PC.
         r_pc             <= r_pc;
         r_if_id_pc       <= '0;
         r_if_id_pc_plus1 <= '0;
         r_if_id_inst     <= NOP_INST;
         r_if_id_valid    <= 1'b0;
      end else begin
         r_pc             <= w_pc_plus1;
         r_if_id_pc       <= r_pc;
         r_if_id_pc_plus1 <= w_pc_plus1;
         r_if_id_inst     <= imem_data;
         r_if_id_valid    <= 1'b1;
      end
   end

   assign if_id_pc       = r_if_id_pc;
   assign if_id_pc_plus1 = r_if_id_pc_plus1;
   assign if_id_inst     = r_if_id_inst;
   assign if_id_valid    = r_if_id_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: small preloaded instruction memory, hand-computed IF/ID values.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        stall = 1'b0;
   logic        mem_conflict = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic [15:0] if_id_pc;
   logic [15:0] if_id_pc_plus1;
   logic [15:0] if_id_inst;
   logic        if_id_valid;
   logic        garbage = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .stall          (stall),
      .mem_conflict   (mem_conflict),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus1 (if_id_pc_plus1),
      .if_id_inst     (if_id_inst),
      .if_id_valid    (if_id_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      case (a)
         16'd0:   mem_rd = 16'h6801;
         16'd1:   mem_rd = 16'h6902;
         16'd2:   mem_rd = 16'h6A03;
         16'd3:   mem_rd = 16'h6B00;
         16'd4:   mem_rd = 16'h9803;
         16'd5:   mem_rd = 16'hD800;
         default: mem_rd = 16'h0000;
      endcase
   endfunction

   // Garbage on the data bus whenever the stage must not sample it.
   assign imem_data = garbage ? 16'hDEAD : mem_rd(imem_addr);

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_if(input string tag, input logic [15:0] addr, input logic [15:0] pc,
                         input logic [15:0] pcp1, input logic [15:0] inst, input logic vld);
      chk({tag, ".addr"},  imem_addr, addr);
      chk({tag, ".pc"},    if_id_pc, pc);
      chk({tag, ".pcp1"},  if_id_pc_plus1, pcp1);
      chk({tag, ".inst"},  if_id_inst, inst);
      chk({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, vld});
   endtask

   initial begin
      // T1: reset then straight-line fetch
      step();
      step();
      chk_if("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0800, 1'b0);
      rst = 1'b0;
      step();
      chk_if("t1e1", 16'h0001, 16'h0000, 16'h0001, 16'h6801, 1'b1);
      step();
      chk_if("t1e2", 16'h0002, 16'h0001, 16'h0002, 16'h6902, 1'b1);

      // T2: two-cycle stall holds everything
      stall = 1'b1; garbage = 1'b1;
      step();
      chk_if("t2s1", 16'h0002, 16'h0001, 16'h0002, 16'h6902, 1'b1);
      step();
      chk_if("t2s2", 16'h0002, 16'h0001, 16'h0002, 16'h6902, 1'b1);
      stall = 1'b0; garbage = 1'b0;
      step();
      chk_if("t2rel", 16'h0003, 16'h0002, 16'h0003, 16'h6A03, 1'b1);
      step();
      chk_if("t2n", 16'h0004, 16'h0003, 16'h0004, 16'h6B00, 1'b1);

      // T3: memory conflict inserts a bubble and refetches
      mem_conflict = 1'b1; garbage = 1'b1;
      step();
      chk_if("t3mc", 16'h0004, 16'h0000, 16'h0000, 16'h0800, 1'b0);
      mem_conflict = 1'b0; garbage = 1'b0;
      step();
      chk_if("t3rel", 16'h0005, 16'h0004, 16'h0005, 16'h9803, 1'b1);

      // T4: redirect beats stall and conflict
      redirect = 1'b1; redirect_pc = 16'h0000; stall = 1'b1; mem_conflict = 1'b1; garbage = 1'b1;
      step();
      chk_if("t4rd", 16'h0000, 16'h0000, 16'h0000, 16'h0800, 1'b0);
      redirect = 1'b0; stall = 1'b0; mem_conflict = 1'b0; garbage = 1'b0;
      step();
      chk_if("t4n", 16'h0001, 16'h0000, 16'h0001, 16'h6801, 1'b1);

      // stall and conflict together behave as a plain stall
      stall = 1'b1; mem_conflict = 1'b1; garbage = 1'b1;
      step();
      chk_if("sc", 16'h0001, 16'h0000, 16'h0001, 16'h6801, 1'b1);
      stall = 1'b0; mem_conflict = 1'b0; garbage = 1'b0;

      // T5: PC wrap at 16'hFFFF
      redirect = 1'b1; redirect_pc = 16'hFFFF;
      step();
      chk_if("t5rd", 16'hFFFF, 16'h0000, 16'h0000, 16'h0800, 1'b0);
      redirect = 1'b0;
      step();
      chk_if("t5wrap", 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
      step();
      chk_if("t5n", 16'h0001, 16'h0000, 16'h0001, 16'h6801, 1'b1);

      // T6: reset mid-stall together with redirect
      stall = 1'b1;
      step();
      rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234; garbage = 1'b1;
      step();
      chk_if("t6rst", 16'h0000, 16'h0000, 16'h0000, 16'h0800, 1'b0);
      rst = 1'b0; redirect = 1'b0; stall = 1'b0; garbage = 1'b0;
      step();
      chk_if("t6e1", 16'h0001, 16'h0000, 16'h0001, 16'h6801, 1'b1);
      step();
      chk_if("t6e2", 16'h0002, 16'h0001, 16'h0002, 16'h6902, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
